// File: rtl/loom_scan_pkg.sv
// ----------------------------------------------------------------------------
// loom_scan_pkg
//   Shared types and default sizing for the loom scan chain controller.
//   - scan_op_e    : operation selected with the start strobe (dump/restore)
//   - scan_state_e : controller state encoding
//   - DEF_CHAIN_LEN / DEF_WORD_W : default chain length and stream word width
// ----------------------------------------------------------------------------
package loom_scan_pkg;

    localparam int DEF_CHAIN_LEN = 24;
    localparam int DEF_WORD_W    = 32;

    typedef enum logic {
        SCAN_OP_DUMP    = 1'b0,
        SCAN_OP_RESTORE = 1'b1
    } scan_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_EMIT,
        ST_DONE
    } scan_state_e;

    // Number of stream words needed to carry a whole chain.
    function automatic int scan_num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/loom_scan_ctrl.sv
// ----------------------------------------------------------------------------
// loom_scan_ctrl
//   Host-side scan chain controller. DUMP streams the chain out as words while
//   looping every shifted-out bit back into the chain head, so the chain is
//   left unchanged. RESTORE takes words from the host and shifts them in.
//   Word k bit j corresponds to the chain bit shifted at position k*WORD_W+j
//   (the first bit out of the tail is word 0 bit 0) for both operations.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, op_i         command strobe and operation (0 dump, 1 restore),
//                         accepted only in IDLE
//   busy_o, done_o        operation in progress / one-cycle completion pulse
//   scan_en_o             chain shift enable
//   scan_in_o             bit driven into the chain head
//   scan_out_i            bit at the chain tail
//   out_valid_o/out_data_o/out_ready_i   dump word stream
//   in_valid_i/in_data_i/in_ready_o      restore word stream
// ----------------------------------------------------------------------------
module loom_scan_ctrl
    import loom_scan_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              op_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              scan_en_o,
    output logic              scan_in_o,
    input  logic              scan_out_i,
    output logic              out_valid_o,
    output logic [WORD_W-1:0] out_data_o,
    input  logic              out_ready_i,
    input  logic              in_valid_i,
    input  logic [WORD_W-1:0] in_data_i,
    output logic              in_ready_o
);

    localparam int BIT_CW = $clog2(CHAIN_LEN + 1);
    localparam int IDX_W  = $clog2(WORD_W + 1);

    localparam logic [BIT_CW-1:0] LAST_BIT   = BIT_CW'(CHAIN_LEN - 1);
    localparam logic [BIT_CW-1:0] CHAIN_BITS = BIT_CW'(CHAIN_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(WORD_W - 1);

    scan_state_e       state;
    scan_op_e          op;
    logic [BIT_CW-1:0] bit_cnt;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] shift_reg;

    logic word_end;
    logic chain_end;

    assign word_end  = (idx == LAST_IDX);
    assign chain_end = (bit_cnt == LAST_BIT);

    // The single shift register doubles as the dump word being assembled.
    assign out_data_o = shift_reg;

    // Dump loops the tail straight back to the head in the same cycle, so the
    // head bit cannot be registered; it is gated to 0 outside SHIFT.
    assign scan_in_o = (state != ST_SHIFT)      ? 1'b0 :
                       (op == SCAN_OP_DUMP)     ? scan_out_i :
                                                  shift_reg[0];

    // Outputs are registered: each transition loads the output values that
    // belong to the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            op          <= SCAN_OP_DUMP;
            bit_cnt     <= '0;
            idx         <= '0;
            shift_reg   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            scan_en_o   <= 1'b0;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        op        <= scan_op_e'(op_i);
                        bit_cnt   <= '0;
                        idx       <= '0;
                        shift_reg <= '0;
                        busy_o    <= 1'b1;
                        if (op_i == SCAN_OP_RESTORE) begin
                            state      <= ST_FETCH;
                            in_ready_o <= 1'b1;
                        end else begin
                            state     <= ST_SHIFT;
                            scan_en_o <= 1'b1;
                        end
                    end
                end

                ST_FETCH: begin
                    if (in_valid_i) begin
                        shift_reg  <= in_data_i;
                        idx        <= '0;
                        in_ready_o <= 1'b0;
                        scan_en_o  <= 1'b1;
                        state      <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    idx     <= idx + 1'b1;
                    if (op == SCAN_OP_DUMP) begin
                        // Word starts cleared, so OR-ing the tail bit in at
                        // idx leaves unused upper bits of a partial word at 0.
                        shift_reg <= shift_reg | (WORD_W'(scan_out_i) << idx);
                    end else begin
                        shift_reg <= shift_reg >> 1;
                    end
                    if (word_end || chain_end) begin
                        scan_en_o <= 1'b0;
                        if (op == SCAN_OP_DUMP) begin
                            state       <= ST_EMIT;
                            out_valid_o <= 1'b1;
                        end else if (chain_end) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state      <= ST_FETCH;
                            in_ready_o <= 1'b1;
                        end
                    end
                end

                ST_EMIT: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        shift_reg   <= '0;
                        idx         <= '0;
                        if (bit_cnt != CHAIN_BITS) begin
                            state     <= ST_SHIFT;
                            scan_en_o <= 1'b1;
                        end else begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end

                default: begin
                    state       <= ST_IDLE;
                    busy_o      <= 1'b0;
                    scan_en_o   <= 1'b0;
                    out_valid_o <= 1'b0;
                    in_ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loom_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_loom_scan_ctrl
//   Two controllers share one 24-flop chain length: u_a streams 32-bit words,
//   u_b streams 8-bit words. Each drives its own behavioural scan chain
//   (head = bit 23, tail = bit 0). sel picks which controller a step talks to.
// ----------------------------------------------------------------------------
module tb_loom_scan_ctrl;

    localparam int CL = 24;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic        out_ready;
    logic        in_valid;
    logic        sel;
    logic [31:0] in_data;

    logic        start_a, start_b;
    logic        busy_a, done_a, scan_en_a, scan_in_a, scan_out_a, out_valid_a, in_ready_a;
    logic        busy_b, done_b, scan_en_b, scan_in_b, scan_out_b, out_valid_b, in_ready_b;
    logic [31:0] out_data_a;
    logic [7:0]  out_data_b;
    logic [7:0]  in_data_b;

    logic [23:0] chain_a, chain_b, ld_val;
    logic        ld_a, ld_b;

    logic        m_busy, m_done, m_scan_en, m_out_valid, m_in_ready;
    logic [31:0] m_out_data;
    logic [23:0] m_chain;

    int vectors = 0;
    int miscompares = 0;

    // results of the most recent run_op
    logic [31:0] got_w [4];
    logic [31:0] wbuf [3];
    int          got_n, cyc_done, en_cnt, done_cnt, burst_n;
    int          burst_len [8];

    assign start_a    = start & ~sel;
    assign start_b    = start & sel;
    assign in_data_b  = in_data[7:0];
    assign scan_out_a = chain_a[0];
    assign scan_out_b = chain_b[0];

    assign m_busy      = sel ? busy_b      : busy_a;
    assign m_done      = sel ? done_b      : done_a;
    assign m_scan_en   = sel ? scan_en_b   : scan_en_a;
    assign m_out_valid = sel ? out_valid_b : out_valid_a;
    assign m_in_ready  = sel ? in_ready_b  : in_ready_a;
    assign m_out_data  = sel ? {24'h0, out_data_b} : out_data_a;
    assign m_chain     = sel ? chain_b : chain_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_a)           chain_a <= ld_val;
        else if (scan_en_a) chain_a <= {scan_in_a, chain_a[23:1]};
    end

    always @(posedge clk) begin
        if (ld_b)           chain_b <= ld_val;
        else if (scan_en_b) chain_b <= {scan_in_b, chain_b[23:1]};
    end

    loom_scan_ctrl #(.CHAIN_LEN(CL), .WORD_W(32)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .op_i(op),
        .busy_o(busy_a), .done_o(done_a), .scan_en_o(scan_en_a),
        .scan_in_o(scan_in_a), .scan_out_i(scan_out_a),
        .out_valid_o(out_valid_a), .out_data_o(out_data_a), .out_ready_i(out_ready),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready_a)
    );

    loom_scan_ctrl #(.CHAIN_LEN(CL), .WORD_W(8)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .op_i(op),
        .busy_o(busy_b), .done_o(done_b), .scan_en_o(scan_en_b),
        .scan_in_o(scan_in_b), .scan_out_i(scan_out_b),
        .out_valid_o(out_valid_b), .out_data_o(out_data_b), .out_ready_i(out_ready),
        .in_valid_i(in_valid), .in_data_i(in_data_b), .in_ready_o(in_ready_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},      32'(m_busy),      32'd0);
        check({tag, "_done"},      32'(m_done),      32'd0);
        check({tag, "_scan_en"},   32'(m_scan_en),   32'd0);
        check({tag, "_out_valid"}, 32'(m_out_valid), 32'd0);
        check({tag, "_in_ready"},  32'(m_in_ready),  32'd0);
        check({tag, "_out_data"},  m_out_data,       32'd0);
    endtask

    task automatic load_chain(input logic s, input logic [23:0] v);
        ld_val = v;
        ld_a   = ~s;
        ld_b   = s;
        tick();
        ld_a = 1'b0;
        ld_b = 1'b0;
    endtask

    // Words per operation and word mask for the selected controller.
    function automatic int nw(input logic s);
        return s ? 3 : 1;
    endfunction

    function automatic logic [31:0] wmask(input logic s);
        return s ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    // Reference: dump word k is the chain bits k*W .. k*W+W-1, zero-padded.
    function automatic logic [31:0] exp_word(input logic s, input int k, input logic [23:0] ch);
        logic [55:0] wide;
        wide = 56'(ch) >> (k * (s ? 8 : 32));
        return wide[31:0] & wmask(s);
    endfunction

    // Reference: restored chain is the concatenation of the words, low word first.
    function automatic logic [23:0] exp_chain(input logic s);
        logic [127:0] acc;
        acc = '0;
        for (int k = 0; k < nw(s); k++)
            acc = acc | (128'(wbuf[k] & wmask(s)) << (k * (s ? 8 : 32)));
        return acc[23:0];
    endfunction

    // One complete operation on controller s. stall: cycles out_ready is held
    // low at the first dump word. gap: idle cycles before each restore word.
    // poke: pulse start (with the other op) at cycles 3 and 26 while busy.
    task automatic run_op(input logic s, input logic rest, input int stall,
                          input int gap, input bit poke);
        int st, gp, wi, run, stop_at;
        bit have_hold;
        logic [31:0] hold;
        got_n = 0; cyc_done = 0; en_cnt = 0; done_cnt = 0; burst_n = 0;
        st = stall; gp = gap; wi = 0; run = 0; stop_at = 400; have_hold = 0; hold = '0;
        sel      = s;
        op       = rest;
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= stop_at; c++) begin
            if (m_scan_en) begin
                en_cnt++;
                run++;
            end else if (run != 0) begin
                if (burst_n < 8) burst_len[burst_n] = run;
                burst_n++;
                run = 0;
            end
            if (m_done) begin
                done_cnt++;
                if (cyc_done == 0) begin
                    cyc_done = c;
                    stop_at  = c + 4;
                end
            end
            if (m_out_valid) begin
                if (st > 0) begin
                    if (have_hold) check("bp_data_stable", m_out_data, hold);
                    hold      = m_out_data;
                    have_hold = 1;
                    check("bp_scan_en_low", 32'(m_scan_en), 32'd0);
                    out_ready = 1'b0;
                    st--;
                end else begin
                    out_ready = 1'b1;
                    if (got_n < 4) got_w[got_n] = m_out_data;
                    got_n++;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (m_in_ready && wi < 3) begin
                if (gp > 0) begin
                    in_valid = 1'b0;
                    gp--;
                end else begin
                    in_valid = 1'b1;
                    in_data  = wbuf[wi];
                    wi++;
                    gp = gap;
                end
            end else begin
                in_valid = 1'b0;
            end
            start = poke && (c == 3 || c == 26);
            op    = poke ? ~rest : rest;
            tick();
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("idle_after_op", 32'(m_busy), 32'd0);
    endtask

    initial begin
        logic [23:0] v;
        logic        s;
        int          stall, gap;

        rst = 1'b1; start = 1'b0; op = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        in_data = '0; sel = 1'b0; ld_a = 1'b0; ld_b = 1'b0; ld_val = '0;
        repeat (3) tick();
        sel = 1'b0; #1; check_idle("rst_a");
        sel = 1'b1; #1; check_idle("rst_b");
        rst = 1'b0;
        tick();
        sel = 1'b0; #1; check_idle("idle_a");

        // basic dump, 32-bit words
        load_chain(1'b0, 24'hCAFE00);
        run_op(1'b0, 1'b0, 0, 0, 1'b0);
        check("dump_nwords",  32'(got_n),    32'd1);
        check("dump_word",    got_w[0],      32'h00CAFE00);
        check("dump_latency", 32'(cyc_done), 32'd26);
        check("dump_en_cnt",  32'(en_cnt),   32'd24);
        check("dump_done_n",  32'(done_cnt), 32'd1);
        check("dump_chain",   32'(m_chain),  32'h00CAFE00);

        // restore then dump; upper byte of the word is ignored
        wbuf[0] = 32'hFF123456;
        run_op(1'b0, 1'b1, 0, 0, 1'b0);
        check("rest_chain",   32'(m_chain),  32'h00123456);
        check("rest_latency", 32'(cyc_done), 32'd26);
        check("rest_en_cnt",  32'(en_cnt),   32'd24);
        run_op(1'b0, 1'b0, 0, 0, 1'b0);
        check("rest_dump_word", got_w[0], 32'h00123456);

        // back-pressure at EMIT
        load_chain(1'b0, 24'hCAFE00);
        run_op(1'b0, 1'b0, 10, 0, 1'b0);
        check("bp_nwords",  32'(got_n),    32'd1);
        check("bp_word",    got_w[0],      32'h00CAFE00);
        check("bp_latency", 32'(cyc_done), 32'd36);
        check("bp_en_cnt",  32'(en_cnt),   32'd24);

        // starvation with 8-bit words
        wbuf[0] = 32'h56; wbuf[1] = 32'h34; wbuf[2] = 32'h12;
        run_op(1'b1, 1'b1, 0, 3, 1'b0);
        check("starve_chain",   32'(m_chain),  32'h00123456);
        check("starve_bursts",  32'(burst_n),  32'd3);
        for (int k = 0; k < 3; k++)
            check($sformatf("starve_burst%0d", k), 32'(burst_len[k]), 32'd8);
        check("starve_latency", 32'(cyc_done), 32'd37);
        run_op(1'b1, 1'b0, 0, 0, 1'b0);
        check("b_dump_nwords",  32'(got_n),    32'd3);
        for (int k = 0; k < 3; k++)
            check($sformatf("b_dump_word%0d", k), got_w[k], wbuf[k]);
        check("b_dump_latency", 32'(cyc_done), 32'd28);

        // reset in the middle of a dump
        load_chain(1'b0, 24'hCAFE00);
        sel = 1'b0; op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid_busy_before", 32'(m_scan_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy",    32'(m_busy),    32'd0);
        check("mid_rst_scan_en", 32'(m_scan_en), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (m_done) done_cnt++;
            tick();
        end
        check("mid_rst_no_done", 32'(done_cnt), 32'd0);
        wbuf[0] = 32'h00ABCDEF;
        run_op(1'b0, 1'b1, 0, 0, 1'b0);
        run_op(1'b0, 1'b0, 0, 0, 1'b0);
        check("mid_rst_word", got_w[0], 32'h00ABCDEF);

        // start while busy is ignored
        load_chain(1'b0, 24'hCAFE00);
        run_op(1'b0, 1'b0, 0, 0, 1'b1);
        check("poke_done_n",  32'(done_cnt), 32'd1);
        check("poke_en_cnt",  32'(en_cnt),   32'd24);
        check("poke_latency", 32'(cyc_done), 32'd26);
        check("poke_word",    got_w[0],      32'h00CAFE00);

        // randomized dump/restore round trips against the reference
        for (int it = 0; it < 12; it++) begin
            s     = 1'($urandom_range(0, 1));
            v     = 24'($urandom);
            stall = int'($urandom_range(0, 5));
            gap   = int'($urandom_range(0, 3));
            load_chain(s, v);
            run_op(s, 1'b0, stall, 0, 1'b0);
            check("rnd_dump_nwords", 32'(got_n), 32'(nw(s)));
            for (int k = 0; k < nw(s); k++)
                check($sformatf("rnd_dump_word%0d", k), got_w[k], exp_word(s, k, v));
            check("rnd_dump_chain",   32'(m_chain),  32'(v));
            check("rnd_dump_latency", 32'(cyc_done), 32'(CL + nw(s) + stall + 1));
            for (int k = 0; k < 3; k++) wbuf[k] = $urandom;
            run_op(s, 1'b1, 0, gap, 1'b0);
            check("rnd_rest_chain",   32'(m_chain),  32'(exp_chain(s)));
            check("rnd_rest_en_cnt",  32'(en_cnt),   32'(CL));
            check("rnd_rest_latency", 32'(cyc_done), 32'(CL + nw(s) * (gap + 1) + 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/loom_scan_ctrl.md
Name: loom_scan_ctrl

Overview:
Host-side scan chain controller that drives the scan ports of an instrumented DUT. It dumps the chain to a word stream and restores it from a word stream. A dump is non-destructive: shifted-out bits loop back into the chain. It sits between the DUT scan chain and the host transport and plays the master role for every scan-enabled register in the design.

Parameters:
CHAIN_LEN, 24, number of flops in the scan chain (>=1)
WORD_W, 32, stream word width (>=1)
NUM_WORDS, ceil(CHAIN_LEN/WORD_W), derived localparam, words per dump/restore

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  one-cycle command strobe, sampled only in IDLE
op_i  in  1  0=DUMP, 1=RESTORE, sampled with start_i
busy_o  out  1  high from cycle after accepted start until DONE exits
done_o  out  1  one-cycle pulse at completion
scan_en_o  out  1  chain shift enable; chain shifts on each edge where high
scan_in_o  out  1  bit into chain head
scan_out_i  in  1  bit at chain tail (valid combinationally before edge)
out_valid_o  out  1  dump word valid
out_data_o  out  WORD_W  dump word
out_ready_i  in  1  dump sink ready
in_valid_i  in  1  restore word valid
in_data_i  in  WORD_W  restore word
in_ready_o  out  1  restore source ready

Behaviour:
- Reset (rst_i high at edge): state IDLE, all outputs 0, bit/word counters 0, shift register 0. Reset mid-operation aborts immediately. scan_en_o is low from the next cycle. Chain contents are undefined; no done_o pulse.
- States: IDLE, FETCH, SHIFT, EMIT, DONE.
- IDLE: start_i=1 -> DUMP goes to SHIFT; RESTORE goes to FETCH. Clear counters. start_i is ignored in all other states.
- FETCH (restore only): in_ready_o=1. On in_valid_i&in_ready_o, load in_data_i into the shift register and go to SHIFT.
- SHIFT: scan_en_o=1 each cycle. bit_cnt increments. The word-local index advances.
  - DUMP: scan_in_o=scan_out_i (loopback). scan_out_i is written to word bit [idx].
  - RESTORE: scan_in_o=shift_reg[0], shift register shifts right. scan_out_i is discarded.
  - Leave SHIFT when the word fills (idx==WORD_W-1) or on the last chain bit (bit_cnt==CHAIN_LEN-1).
  - DUMP exits to EMIT. RESTORE exits to FETCH, or to DONE if that was the last bit.
- EMIT (dump only): out_valid_o=1, out_data_o stable until accepted.
  - On out_ready_i, clear the word.
  - Go to SHIFT if bits remain, else DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. busy_o low in IDLE.
- Bit ordering: first bit out of the tail -> word 0 bit 0. Word k bit j = chain bit shifted at position k*WORD_W+j. Restore uses the identical ordering, so dump after restore returns the same words.
- Final partial word: unused upper bits are 0 on dump and ignored on restore.
- Total scan_en_o high cycles per operation = CHAIN_LEN exactly, regardless of stalls.
- scan_en_o is never high in IDLE, FETCH, EMIT, or DONE. Back-pressure and starvation stall shifting; they never drop bits.
- Latency without stalls:
  - DUMP: CHAIN_LEN + NUM_WORDS + 1 cycles from accepted start to done_o.
  - RESTORE: CHAIN_LEN + NUM_WORDS + 1 cycles.
- Counters sized $clog2(CHAIN_LEN+1) and $clog2(WORD_W+1). No wrap occurs within one operation.

Decomposition:
- Package loom_scan_pkg:
  - op enum (SCAN_OP_DUMP, SCAN_OP_RESTORE)
  - state enum
  - default CHAIN_LEN/WORD_W constants
- No sub-module. The datapath is a single WORD_W shift register shared by both ops: it fills in DUMP and drains in RESTORE.

Test Plan:
- Bench model: 24-flop chain preloaded 24'hCAFE00, tail = bit 0.
- Basic dump, out_ready_i=1: one word 32'h00CAFE00. done_o after 26 cycles. Chain still reads 24'hCAFE00. scan_en_o high exactly 24 cycles.
- Restore 32'hFF123456 then dump: chain = 24'h123456. Dump word = 32'h00123456 (upper bits ignored on restore, zero on dump).
- Back-pressure: out_ready_i low 10 cycles during EMIT.
  - out_data_o stable, scan_en_o low throughout.
  - Word 32'h00CAFE00 accepted once; done_o 10 cycles later.
- Starvation: WORD_W=8, CHAIN_LEN=24, restore words 8'h56, 8'h34, 8'h12 with gaps.
  - Chain = 24'h123456.
  - scan_en_o pulses in 3 bursts of 8.
- Reset mid-SHIFT (cycle 5 of dump): next cycle busy_o=0, scan_en_o=0, no done_o. A following restore+dump of 24'hABCDEF returns 32'h00ABCDEF.
- start_i asserted while busy: ignored. Exactly one done_o and 24 shift cycles.
